// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller port between a download writer
// and four read ports; the writer has absolute priority, reads rotate.
//
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   wr_req/wr_addr/wr_data   download write request (level) and payload
//   wr_ack                   one-cycle pulse when the write is accepted
//   rd_req[3:0]              read requests, one per port (level)
//   rd_addr_0..rd_addr_3     read address per port
//   rd_ack[3:0]              one-cycle pulse when a port's read is accepted
//   rd_valid[3:0]            one-cycle pulse when rd_q holds a port's data
//   rd_q                     read data, shared by all ports
//   sdram_addr/data/we/req   request towards the controller
//   sdram_ack                controller accepted the request
//   sdram_valid/sdram_q      controller read data and its strobe

module sdram_arbiter #(
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ack,
    input  logic [3:0]            rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr_0,
    input  logic [ADDR_WIDTH-1:0] rd_addr_1,
    input  logic [ADDR_WIDTH-1:0] rd_addr_2,
    input  logic [ADDR_WIDTH-1:0] rd_addr_3,
    output logic [3:0]            rd_ack,
    output logic [3:0]            rd_valid,
    output logic [DATA_WIDTH-1:0] rd_q,
    output logic [ADDR_WIDTH-1:0] sdram_addr,
    output logic [DATA_WIDTH-1:0] sdram_data,
    output logic                  sdram_we,
    output logic                  sdram_req,
    input  logic                  sdram_ack,
    input  logic                  sdram_valid,
    input  logic [DATA_WIDTH-1:0] sdram_q
);

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] WAIT_ACK   = 2'd1;
    localparam logic [1:0] WAIT_VALID = 2'd2;

    logic [1:0]            state;
    logic [1:0]            rr_ptr;
    logic [1:0]            grant;
    logic [ADDR_WIDTH-1:0] rd_addr [4];
    logic                  rr_hit;
    logic [1:0]            rr_sel;
    logic [1:0]            rr_idx;
    logic                  ack_hit;
    logic                  done_read;

    assign rd_addr[0] = rd_addr_0;
    assign rd_addr[1] = rd_addr_1;
    assign rd_addr[2] = rd_addr_2;
    assign rd_addr[3] = rd_addr_3;

    assign rd_q      = sdram_q;
    assign sdram_req = (state == WAIT_ACK);

    // First requesting port at or after rr_ptr, wrapping modulo 4.
    always_comb begin
        rr_hit = 1'b0;
        rr_sel = rr_ptr;
        rr_idx = rr_ptr;
        for (int i = 0; i < 4; i++) begin
            rr_idx = rr_ptr + 2'(i);
            if (!rr_hit && rd_req[rr_idx]) begin
                rr_hit = 1'b1;
                rr_sel = rr_idx;
            end
        end
    end

    // Acks and data strobes are decoded straight from the controller
    // handshake so the requester sees them in the same cycle.
    always_comb begin
        ack_hit   = (state == WAIT_ACK) && sdram_ack;
        done_read = (ack_hit && !sdram_we && sdram_valid)
                  || ((state == WAIT_VALID) && sdram_valid);
        wr_ack    = ack_hit && sdram_we;
        rd_ack    = 4'b0000;
        rd_valid  = 4'b0000;
        if (ack_hit && !sdram_we) begin
            rd_ack = 4'b0001 << grant;
        end
        if (done_read) begin
            rd_valid = 4'b0001 << grant;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= 2'd0;
            grant      <= 2'd0;
            sdram_we   <= 1'b0;
            sdram_addr <= '0;
            sdram_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_req) begin
                        sdram_addr <= wr_addr;
                        sdram_data <= wr_data;
                        sdram_we   <= 1'b1;
                        state      <= WAIT_ACK;
                    end else if (rr_hit) begin
                        sdram_addr <= rd_addr[rr_sel];
                        sdram_we   <= 1'b0;
                        grant      <= rr_sel;
                        rr_ptr     <= rr_sel + 2'd1;
                        state      <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (sdram_ack) begin
                        // A read whose data arrives with the ack is complete.
                        if (!sdram_we && !sdram_valid) begin
                            state <= WAIT_VALID;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                WAIT_VALID: begin
                    if (sdram_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: randomized requesters and controller around sdram_arbiter,
// with a transaction-level reference model feeding a scoreboard monitor.

module tb_sdram_arbiter;

    localparam int AW = 23;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic [3:0]    rd_req;
    logic [AW-1:0] ra [4];
    logic [3:0]    rd_ack;
    logic [3:0]    rd_valid;
    logic [DW-1:0] rd_q;
    logic [AW-1:0] sdram_addr;
    logic [DW-1:0] sdram_data;
    logic          sdram_we;
    logic          sdram_req;
    logic          sdram_ack;
    logic          sdram_valid;
    logic [DW-1:0] sdram_q;

    sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk),
        .reset(reset),
        .wr_req(wr_req),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_ack(wr_ack),
        .rd_req(rd_req),
        .rd_addr_0(ra[0]),
        .rd_addr_1(ra[1]),
        .rd_addr_2(ra[2]),
        .rd_addr_3(ra[3]),
        .rd_ack(rd_ack),
        .rd_valid(rd_valid),
        .rd_q(rd_q),
        .sdram_addr(sdram_addr),
        .sdram_data(sdram_data),
        .sdram_we(sdram_we),
        .sdram_req(sdram_req),
        .sdram_ack(sdram_ack),
        .sdram_valid(sdram_valid),
        .sdram_q(sdram_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] data;
    } txn_t;

    typedef struct {
        int            cyc;
        logic          rst;
        logic          req;
        logic          wack;
        logic [3:0]    rack;
        logic [3:0]    rval;
        logic [DW-1:0] q;
    } rsp_t;

    txn_t txq[$];
    rsp_t rsq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: one outstanding transaction, tracked as
    // free / asking the controller / awaiting read data.
    int            m_phase = 0;
    bit            m_write = 1'b0;
    int            m_port  = 0;
    int            m_rr    = 0;
    logic [DW-1:0] m_data  = '0;

    always @(negedge clk) begin : model
        rsp_t r;
        txn_t t;
        int   p;
        cyc++;
        r.cyc  = cyc;
        r.rst  = 1'b0;
        r.req  = 1'b0;
        r.wack = 1'b0;
        r.rack = 4'b0;
        r.rval = 4'b0;
        r.q    = '0;
        if (reset) begin
            m_phase = 0;
            m_rr    = 0;
            m_data  = '0;
            r.rst   = 1'b1;
            txq.delete();
        end else if (m_phase == 1) begin
            r.req = 1'b1;
            if (sdram_ack) begin
                if (m_write) begin
                    r.wack  = 1'b1;
                    m_phase = 0;
                end else begin
                    r.rack[m_port] = 1'b1;
                    m_phase = 2;
                    if (sdram_valid) begin
                        r.rval[m_port] = 1'b1;
                        r.q     = sdram_q;
                        m_phase = 0;
                    end
                end
            end
        end else if (m_phase == 2) begin
            if (sdram_valid) begin
                r.rval[m_port] = 1'b1;
                r.q     = sdram_q;
                m_phase = 0;
            end
        end else if (wr_req) begin
            t.cyc   = cyc + 1;
            t.addr  = wr_addr;
            t.we    = 1'b1;
            t.data  = wr_data;
            m_data  = wr_data;
            m_write = 1'b1;
            m_phase = 1;
            txq.push_back(t);
        end else if (rd_req != 4'b0) begin
            p = -1;
            for (int i = 0; i < 4; i++) begin
                if (p < 0 && rd_req[(m_rr + i) % 4]) p = (m_rr + i) % 4;
            end
            t.cyc   = cyc + 1;
            t.addr  = ra[p];
            t.we    = 1'b0;
            t.data  = m_data;
            m_port  = p;
            m_write = 1'b0;
            m_rr    = (p + 1) % 4;
            m_phase = 1;
            txq.push_back(t);
        end
        rsq.push_back(r);
    end

    // Monitor: compares DUT outputs against the scoreboard queues.
    logic prev_req = 1'b0;
    bit   have_cur = 1'b0;
    txn_t cur;

    always @(negedge clk) begin : monitor
        rsp_t r;
        #1;
        if (rsq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_queue cyc=%0d got=empty expected=entry", cyc);
        end else begin
            r = rsq.pop_front();
            chk("sdram_req", 64'(sdram_req), 64'(r.req));
            chk("wr_ack", 64'(wr_ack), 64'(r.wack));
            chk("rd_ack", 64'(rd_ack), 64'(r.rack));
            chk("rd_valid", 64'(rd_valid), 64'(r.rval));
            if (r.rval != 4'b0) chk("rd_q", 64'(rd_q), 64'(r.q));
            if (r.rst) begin
                chk("rst_addr", 64'(sdram_addr), 64'd0);
                chk("rst_we", 64'(sdram_we), 64'd0);
                chk("rst_data", 64'(sdram_data), 64'd0);
                have_cur = 1'b0;
            end
        end
        if (sdram_req && !prev_req) begin
            if (txq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL grant cyc=%0d got=unexpected expected=none", cyc);
            end else begin
                cur = txq.pop_front();
                have_cur = 1'b1;
                chk("grant_cycle", 64'(cyc), 64'(cur.cyc));
                chk("grant_addr", 64'(sdram_addr), 64'(cur.addr));
                chk("grant_we", 64'(sdram_we), 64'(cur.we));
                chk("grant_data", 64'(sdram_data), 64'(cur.data));
            end
        end else if (sdram_req && have_cur) begin
            chk("hold_addr", 64'(sdram_addr), 64'(cur.addr));
            chk("hold_we", 64'(sdram_we), 64'(cur.we));
            chk("hold_data", 64'(sdram_data), 64'(cur.data));
        end
        prev_req = sdram_req;
    end

    function automatic bit roll(int pct);
        return int'($urandom_range(0, 99)) < pct;
    endfunction

    // Requesters drop their level one cycle after their ack; idle ports
    // scramble their addresses to show they have no effect.
    task automatic run_phase(int n, int pw, int pr, int pa, int pv, bit rst_en);
        logic       sw;
        logic [3:0] sr;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            #2;
            sw = wr_ack;
            sr = rd_ack;
            @(posedge clk);
            #1;
            if (reset) reset = 1'b0;
            else if (rst_en && roll(2)) reset = 1'b1;
            if (wr_req && sw) begin
                wr_req = 1'b0;
            end else if (!wr_req) begin
                wr_addr = AW'($urandom);
                wr_data = DW'($urandom);
                wr_req  = roll(pw);
            end
            for (int i = 0; i < 4; i++) begin
                if (rd_req[i] && sr[i]) begin
                    rd_req[i] = 1'b0;
                end else if (!rd_req[i]) begin
                    ra[i]     = AW'($urandom);
                    rd_req[i] = roll(pr);
                end
            end
            sdram_ack   = roll(pa);
            sdram_valid = roll(pv);
            sdram_q     = DW'($urandom);
        end
    endtask

    initial begin
        reset       = 1'b1;
        wr_req      = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        rd_req      = 4'b0;
        sdram_ack   = 1'b0;
        sdram_valid = 1'b0;
        sdram_q     = '0;
        for (int i = 0; i < 4; i++) ra[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        run_phase(600, 15, 25, 40, 30, 1'b1);
        run_phase(200, 0, 100, 100, 100, 1'b0);
        run_phase(200, 0, 0, 50, 50, 1'b0);
        run_phase(150, 0, 0, 40, 60, 1'b0);
        run_phase(400, 60, 30, 30, 20, 1'b1);
        run_phase(300, 20, 40, 70, 10, 1'b1);
        run_phase(100, 0, 0, 100, 100, 1'b0);
        @(negedge clk);
        #3;
        chk("txq_left", 64'(txq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
